// File: rtl/iomem_timer_pkg.sv
// iomem_timer_pkg: register map, bit positions and byte-lane merge shared by the timer files
package iomem_timer_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int ENABLE      = 0;
  localparam int AUTO_RELOAD = 1;
  localparam int IRQ_EN      = 2;
  localparam int EXPIRED     = 0;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [3:0] wstrb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/iomem_timer_count.sv
// iomem_timer_count: prescaler, down-counter and expiry detection
module iomem_timer_count #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        auto_reload,
  input  logic [31:0] reload,
  input  logic        count_we,
  input  logic        ctrl_we,
  input  logic [31:0] count_wdata,
  output logic [31:0] count,
  output logic        expire
);
  logic [15:0] presc_d, presc_q;
  logic [31:0] count_d, count_q;
  logic        tick;
  always_comb begin
    tick    = enable && presc_q == 16'(PRESCALE - 1);
    expire  = tick && count_q <= 32'd1;
    presc_d = (!enable || count_we || tick) ? 16'd0 : presc_q + 16'd1;
    // a bus write to CTRL or COUNT on a tick edge drops the tick's count update
    count_d = count_we ? count_wdata :
              (ctrl_we || !tick) ? count_q :
              expire ? (auto_reload ? reload : 32'd0) : count_q - 32'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
endmodule

// File: rtl/iomem_timer.sv
// iomem_timer: iomem bus responder with prescaled auto-reload down-counter and level irq
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);
  logic        ready_d, ready_q, irq_d, irq_q, expired_d, expired_q, expire, acc, wr;
  logic [2:0]  ctrl_d, ctrl_q;
  logic [31:0] reload_d, reload_q, rdata_d, rdata_q, count, rd_mux, merged;
  logic [1:0]  idx;
  logic        unused_addr;
  assign unused_addr = ^iomem_addr[1:0];
  always_comb begin
    idx       = iomem_addr[3:2];
    acc       = iomem_valid && iomem_addr[31:4] == BASE_ADDR[31:4] && !ready_q;
    wr        = acc && iomem_wstrb != 4'd0;
    rd_mux    = idx == REG_CTRL   ? {29'd0, ctrl_q} :
                idx == REG_RELOAD ? reload_q :
                idx == REG_COUNT  ? count : {31'd0, expired_q};
    merged    = merge_bytes(rd_mux, iomem_wdata, iomem_wstrb);
    ctrl_d    = (wr && idx == REG_CTRL) ? merged[2:0] :
                (expire && !ctrl_q[AUTO_RELOAD]) ? ctrl_q & ~(3'b001 << ENABLE) : ctrl_q;
    reload_d  = (wr && idx == REG_RELOAD) ? merged : reload_q;
    // a new expiry beats a simultaneous write-1-to-clear
    expired_d = expire || (expired_q &&
                !(wr && idx == REG_STATUS && iomem_wstrb[0] && iomem_wdata[EXPIRED]));
    irq_d     = expired_q && ctrl_q[IRQ_EN];
    ready_d   = acc;
    rdata_d   = acc ? rd_mux : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      expired_q <= 1'b0;
      ctrl_q    <= '0;
      reload_q  <= '0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      expired_q <= expired_d;
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
    end
  end
  iomem_timer_count #(.PRESCALE(PRESCALE)) u_count (
    .clk         (clk),
    .reset       (reset),
    .enable      (ctrl_q[ENABLE]),
    .auto_reload (ctrl_q[AUTO_RELOAD]),
    .reload      (reload_q),
    .count_we    (wr && idx == REG_COUNT),
    .ctrl_we     (wr && idx == REG_CTRL),
    .count_wdata (merged),
    .count       (count),
    .expire      (expire)
  );
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;
endmodule
